pulse_interval_tx: RTL and testbench

- Transmitter for the single-wire pulse-interval link decoded by the on-chip receiver FSM (DATA_IN side).
- Accepts a DATA_W-bit word over a valid/ready handshake and serialises it onto DATA_OUT as a preamble followed by one two-pulse symbol per bit, MSB first.
- Used on the test/host side to drive the receiver, and as a loopback source in bench and FPGA bring-up.

---
 rtl/pulse_link_pkg.sv | 48 ++++
 rtl/pulse_interval_tx_if.sv | 39 +++
 rtl/pulse_symbol_gen.sv | 71 +++++++
 rtl/pulse_interval_tx.sv | 139 +++++++++++++
 tb/tb_pulse_interval_tx.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pulse_link_pkg.sv
// ============================================================================
// pulse_link_pkg : shared state encodings and link timing for the
// pulse-interval transmitter and receiver.
// Optional feature macro: PULSE_TX_PARITY_EN (appends an even-parity symbol).
// Revision: 1.0
// ============================================================================
`default_nettype none

package pulse_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE_HI  = 3'd1,
        ST_PRE_LO  = 3'd2,
        ST_GAP_A   = 3'd3,
        ST_PULSE_A = 3'd4,
        ST_GAP_B   = 3'd5,
        ST_PULSE_B = 3'd6,
        ST_GUARD   = 3'd7
    } pulse_state_e;

    localparam int DEF_DATA_W       = 4;
    localparam int DEF_START_PULSES = 3;
    localparam int DEF_SHORT_GAP    = 2;
    localparam int DEF_LONG_GAP     = 6;
    localparam int DEF_IDLE_GAP     = 16;

    // One symbol: both gaps plus its two single-cycle pulses.
    localparam int DEF_SYMBOL_LEN   = DEF_SHORT_GAP + DEF_LONG_GAP + 2;

`ifdef PULSE_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int PARITY_SYMS = PARITY_EN ? 1 : 0;

    function automatic int symbol_len(input int short_gap, input int long_gap);
        return short_gap + long_gap + 2;
    endfunction

    function automatic int gap_cnt_w(input int long_gap, input int idle_gap);
        return $clog2(((long_gap > idle_gap) ? long_gap : idle_gap) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_interval_tx_if.sv
// ============================================================================
// pulse_interval_tx_if : word handshake and serial line of the pulse-interval
// transmitter. master = word source / line observer, slave = transmitter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pulse_interval_tx_if
    import pulse_link_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] TX_DATA_IN;
    logic              TX_VALID_IN;
    logic              TX_READY_OUT;
    logic              DATA_OUT;
    logic              BUSY_OUT;
    logic              FRAME_DONE_OUT;

    modport master (
        output TX_DATA_IN,
        output TX_VALID_IN,
        input  TX_READY_OUT,
        input  DATA_OUT,
        input  BUSY_OUT,
        input  FRAME_DONE_OUT
    );

    modport slave (
        input  TX_DATA_IN,
        input  TX_VALID_IN,
        output TX_READY_OUT,
        output DATA_OUT,
        output BUSY_OUT,
        output FRAME_DONE_OUT
    );
endinterface

`default_nettype wire

// File: rtl/pulse_symbol_gen.sv
// ============================================================================
// pulse_symbol_gen : sequences one GAP_A/PULSE_A/GAP_B/PULSE_B symbol per start.
// Exposes its next phase so the parent can register line outputs from it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_symbol_gen
    import pulse_link_pkg::*;
#(
    parameter int SHORT_GAP = DEF_SHORT_GAP,
    parameter int LONG_GAP  = DEF_LONG_GAP,
    parameter int CNT_W     = gap_cnt_w(DEF_LONG_GAP, DEF_IDLE_GAP)
)(
    input  wire logic   clk_i,
    input  wire logic   rst_n_i,
    input  wire logic   start_i,
    input  wire logic   bit_i,
    output pulse_state_e phase_d_o,
    output logic        done_o
);

    pulse_state_e     phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_q, bit_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        case (phase_q)
            ST_GAP_A: begin
                if (cnt_q == CNT_W'(1)) phase_d = ST_PULSE_A;
                else                    cnt_d   = cnt_q - 1'b1;
            end
            ST_PULSE_A: begin
                phase_d = ST_GAP_B;
                cnt_d   = bit_q ? CNT_W'(SHORT_GAP) : CNT_W'(LONG_GAP);
            end
            ST_GAP_B: begin
                if (cnt_q == CNT_W'(1)) phase_d = ST_PULSE_B;
                else                    cnt_d   = cnt_q - 1'b1;
            end
            default: phase_d = ST_IDLE;
        endcase
        // A new symbol may begin straight out of PULSE_B so bits abut with no idle cycle.
        if (start_i && (phase_q == ST_IDLE || phase_q == ST_PULSE_B)) begin
            phase_d = ST_GAP_A;
            cnt_d   = bit_i ? CNT_W'(LONG_GAP) : CNT_W'(SHORT_GAP);
            bit_d   = bit_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    assign phase_d_o = phase_d;
    assign done_o    = (phase_q == ST_PULSE_B);

endmodule

`default_nettype wire

// File: rtl/pulse_interval_tx.sv
// ============================================================================
// pulse_interval_tx : serialises a word as preamble + one two-pulse symbol per
// bit (MSB first), then holds an idle guard. Macro PULSE_TX_PARITY_EN adds a parity symbol.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pulse_interval_tx
    import pulse_link_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int START_PULSES = DEF_START_PULSES,
    parameter int SHORT_GAP    = DEF_SHORT_GAP,
    parameter int LONG_GAP     = DEF_LONG_GAP,
    parameter int IDLE_GAP     = DEF_IDLE_GAP
)(
    input  wire logic          CLK_IN,
    input  wire logic          RSTN_IN,
    pulse_interval_tx_if.slave tx_if
);

    localparam int NSYM  = DATA_W + PARITY_SYMS;
    localparam int CNT_W = gap_cnt_w(LONG_GAP, IDLE_GAP);
    localparam int PRE_W = $clog2(START_PULSES + 1);
    localparam int SYM_W = $clog2(NSYM + 1);

    pulse_state_e     state_q, state_d;
    logic [CNT_W-1:0] guard_q, guard_d;
    logic [PRE_W-1:0] pre_left_q, pre_left_d;
    logic [SYM_W-1:0] sym_left_q, sym_left_d;
    logic [NSYM-1:0]  shreg_q, shreg_d;
    logic [NSYM-1:0]  load_word;
    logic             data_q, ready_q, busy_q, done_q;

    pulse_state_e     sg_phase_d;
    logic             sg_start;
    logic             sg_done;

`ifdef PULSE_TX_PARITY_EN
    assign load_word = {tx_if.TX_DATA_IN, ^tx_if.TX_DATA_IN};
`else
    assign load_word = tx_if.TX_DATA_IN;
`endif

    // Start a symbol after the last preamble pulse, and after every PULSE_B that has a successor.
    assign sg_start = ((state_q == ST_PRE_HI) && (pre_left_q == '0)) ||
                      (sg_done && (sym_left_q != '0));

    pulse_symbol_gen #(
        .SHORT_GAP (SHORT_GAP),
        .LONG_GAP  (LONG_GAP),
        .CNT_W     (CNT_W)
    ) u_symbol_gen (
        .clk_i     (CLK_IN),
        .rst_n_i   (RSTN_IN),
        .start_i   (sg_start),
        .bit_i     (shreg_q[NSYM-1]),
        .phase_d_o (sg_phase_d),
        .done_o    (sg_done)
    );

    always_comb begin
        state_d    = state_q;
        guard_d    = guard_q;
        pre_left_d = pre_left_q;
        sym_left_d = sym_left_q;
        shreg_d    = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_if.TX_VALID_IN && ready_q) begin
                    state_d    = ST_PRE_HI;
                    pre_left_d = PRE_W'(START_PULSES - 1);
                    sym_left_d = SYM_W'(NSYM);
                    shreg_d    = load_word;
                end
            end
            ST_PRE_HI: begin
                if (pre_left_q == '0) begin
                    state_d = sg_phase_d;
                end else begin
                    state_d    = ST_PRE_LO;
                    pre_left_d = pre_left_q - 1'b1;
                end
            end
            ST_PRE_LO: state_d = ST_PRE_HI;
            ST_GAP_A, ST_PULSE_A, ST_GAP_B: state_d = sg_phase_d;
            ST_PULSE_B: begin
                if (sym_left_q == '0) begin
                    state_d = ST_GUARD;
                    guard_d = CNT_W'(IDLE_GAP);
                end else begin
                    state_d = sg_phase_d;
                end
            end
            default: begin
                if (guard_q == CNT_W'(1)) state_d = ST_IDLE;
                else                      guard_d = guard_q - 1'b1;
            end
        endcase
        if (sg_start) begin
            sym_left_d = sym_left_q - 1'b1;
            shreg_d    = shreg_q << 1;
        end
    end

    always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
        if (!RSTN_IN) begin
            state_q    <= ST_GUARD;
            guard_q    <= CNT_W'(IDLE_GAP);
            pre_left_q <= '0;
            sym_left_q <= '0;
            shreg_q    <= '0;
            data_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            guard_q    <= guard_d;
            pre_left_q <= pre_left_d;
            sym_left_q <= sym_left_d;
            shreg_q    <= shreg_d;
            data_q     <= (state_d == ST_PRE_HI) || (state_d == ST_PULSE_A) ||
                          (state_d == ST_PULSE_B);
            ready_q    <= (state_d == ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
            // sym_left_q is already zero throughout the final symbol.
            done_q     <= (state_d == ST_PULSE_B) && (sym_left_q == '0);
        end
    end

    assign tx_if.TX_READY_OUT   = ready_q;
    assign tx_if.DATA_OUT       = data_q;
    assign tx_if.BUSY_OUT       = busy_q;
    assign tx_if.FRAME_DONE_OUT = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_interval_tx.sv
// ============================================================================
// tb_pulse_interval_tx : randomized and directed stimulus against a timeline
// model built from the frame timing rules.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pulse_interval_tx;
    import pulse_link_pkg::*;

    localparam int DW   = 4;
    localparam int SP   = 3;
    localparam int SG   = 2;
    localparam int LG   = 6;
    localparam int IG   = 16;
    localparam int MAXC = 8192;
`ifdef PULSE_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic [DW-1:0] data;

    pulse_interval_tx_if #(.DATA_W(DW)) bus();

    assign bus.TX_VALID_IN = valid;
    assign bus.TX_DATA_IN  = data;

    pulse_interval_tx #(
        .DATA_W       (DW),
        .START_PULSES (SP),
        .SHORT_GAP    (SG),
        .LONG_GAP     (LG),
        .IDLE_GAP     (IG)
    ) dut (
        .CLK_IN  (clk),
        .RSTN_IN (rst_n),
        .tx_if   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_at = MAXC;
    int accepts  = 0;
    int last_t   = 0;
    bit exp_hi   [MAXC];
    bit exp_done [MAXC];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Lay out the whole frame on the expected timeline from the accept cycle t.
    task automatic model_accept(input int t, input logic [DW-1:0] w);
        bit syms[$];
        int base;
        int last;
        int ga;
        int gb;
        for (int k = 0; k < SP; k++) exp_hi[t + 1 + 2*k] = 1'b1;
        for (int i = DW - 1; i >= 0; i--) syms.push_back(w[i]);
        if (PAR) syms.push_back(^w);
        base = t + 2*SP;
        last = base;
        foreach (syms[i]) begin
            ga = syms[i] ? LG : SG;
            gb = syms[i] ? SG : LG;
            exp_hi[base + ga] = 1'b1;
            last = base + ga + 1 + gb;
            exp_hi[last] = 1'b1;
            base += SG + LG + 2;
        end
        exp_done[last] = 1'b1;
        ready_at = base + IG;
        last_t   = t;
        accepts++;
    endtask

    task automatic step();
        bit er;
        er = (cyc >= ready_at);
        check_eq("DATA_OUT",       bus.DATA_OUT,       32'(exp_hi[cyc]));
        check_eq("TX_READY_OUT",   bus.TX_READY_OUT,   32'(er));
        check_eq("BUSY_OUT",       bus.BUSY_OUT,       32'(!er));
        check_eq("FRAME_DONE_OUT", bus.FRAME_DONE_OUT, 32'(exp_done[cyc]));
        if (er && valid) model_accept(cyc, data);
        @(negedge clk);
        cyc++;
        if (cyc >= MAXC - 100) begin
            $display("FAIL cycle_budget @cyc %0d: got overrun, expected < %0d", cyc, MAXC - 100);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic apply_reset(input int hold);
        rst_n = 1'b0;
        #1;
        check_eq("rst_DATA_OUT",       bus.DATA_OUT,       0);
        check_eq("rst_TX_READY_OUT",   bus.TX_READY_OUT,   0);
        check_eq("rst_BUSY_OUT",       bus.BUSY_OUT,       1);
        check_eq("rst_FRAME_DONE_OUT", bus.FRAME_DONE_OUT, 0);
        for (int i = cyc; i < MAXC; i++) begin
            exp_hi[i]   = 1'b0;
            exp_done[i] = 1'b0;
        end
        ready_at = MAXC;
        repeat (hold) step();
        rst_n    = 1'b1;
        ready_at = cyc + IG;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        int a0;
        a0    = accepts;
        valid = 1'b1;
        data  = w;
        for (int i = 0; i < 200 && accepts == a0; i++) step();
        if (accepts == a0) check_eq("accept_timeout", 0, 1);
        valid = 1'b0;
        data  = DW'($urandom);
    endtask

    initial begin
        int a0;
        rst_n = 1'b1;
        valid = 1'b0;
        data  = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        apply_reset(2);

        // Quiet line, ready after the post-reset guard.
        repeat (20) step();

        send_word(4'b1010);
        repeat (70) step();

        // Valid held: 0000 then 1111 back to back.
        a0    = accepts;
        valid = 1'b1;
        data  = 4'b0000;
        for (int i = 0; i < 200 && accepts == a0; i++) step();
        data = 4'b1111;
        for (int i = 0; i < 200 && accepts == a0 + 1; i++) step();
        if (accepts != a0 + 2) check_eq("b2b_accepts", accepts - a0, 2);
        valid = 1'b0;
        repeat (70) step();

        // Reset in the middle of a frame, on a high cycle of the line.
        send_word(4'b1010);
        repeat (17) step();
        apply_reset(2);
        repeat (18) step();
        send_word(4'b0110);
        repeat (70) step();

        // Random valid/data traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            valid = ($urandom_range(0, 3) == 0);
            data  = DW'($urandom);
            if ($urandom_range(0, 499) == 0) apply_reset($urandom_range(1, 3));
            else                             step();
        end
        valid = 1'b0;
        repeat (80) step();

        for (int w = 0; w < 16; w++) send_word(DW'(w));
        repeat (80) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
